// File: rtl/serial_parity_checker.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_checker
// Description : Accumulates FRAME_LEN serial data bits, then checks the trailing
//               parity bit; even/odd parity selected per frame by mode_odd.
//               Optional 8-bit saturating error counter under PAR_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_parity_checker #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_odd,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       bit_ready,
    output logic       par_valid,
    output logic       par_out,
    output logic       par_err,
`ifdef PAR_ERR_CNT_EN
    output logic [7:0] err_cnt,
`endif
    input  logic       par_ack
);

    localparam int            CW    = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] c_len = CW'(FRAME_LEN);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_data  = 2'd1;
    localparam logic [1:0] c_check = 2'd2;
    localparam logic [1:0] c_hold  = 2'd3;

    logic [1:0]    r_state;
    logic          r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_par_out;
    logic          r_par_err;
    logic          w_xfer;
    logic [CW-1:0] w_cnt_nxt;

    assign bit_ready = (r_state != c_hold);
    assign par_valid = (r_state == c_hold);
    assign par_out   = r_par_out;
    assign par_err   = r_par_err;
    assign w_xfer    = bit_valid & bit_ready;
    assign w_cnt_nxt = r_cnt + CW'(1);

    // mode_odd is folded into the accumulator on the first bit, so later
    // changes to it cannot disturb the frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_acc     <= 1'b0;
            r_cnt     <= '0;
            r_par_out <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_xfer) begin
                        r_acc   <= bit_in ^ mode_odd;
                        r_cnt   <= CW'(1);
                        r_state <= (FRAME_LEN == 1) ? c_check : c_data;
                    end
                end
                c_data: begin
                    if (w_xfer) begin
                        r_acc <= r_acc ^ bit_in;
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == c_len) begin
                            r_state <= c_check;
                        end
                    end
                end
                c_check: begin
                    if (w_xfer) begin
                        r_par_out <= r_acc;
                        r_par_err <= r_acc ^ bit_in;
                        r_state   <= c_hold;
                    end
                end
                default: begin
                    if (par_ack) begin
                        r_state <= c_idle;
                    end
                end
            endcase
        end
    end

`ifdef PAR_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if ((r_state == c_check) && w_xfer && (r_acc ^ bit_in)
                     && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_parity_checker
// Description : Directed and randomized frames against an arithmetic parity
//               model; one 8-bit and one 1-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_parity_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode, valid, bin, ack;
    logic [1:0] ready, pv, po, pe;
`ifdef PAR_ERR_CNT_EN
    logic [7:0] ec8, ec1;
`endif

    int ncomp = 0;
    int nfail = 0;
    logic exp_po [2];
    logic exp_pe [2];
    int   exp_ec [2];

    always #5 clk = ~clk;

    serial_parity_checker #(.FRAME_LEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode_odd(mode[0]), .bit_valid(valid[0]),
        .bit_in(bin[0]), .bit_ready(ready[0]), .par_valid(pv[0]),
        .par_out(po[0]), .par_err(pe[0]),
`ifdef PAR_ERR_CNT_EN
        .err_cnt(ec8),
`endif
        .par_ack(ack[0])
    );

    serial_parity_checker #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode_odd(mode[1]), .bit_valid(valid[1]),
        .bit_in(bin[1]), .bit_ready(ready[1]), .par_valid(pv[1]),
        .par_out(po[1]), .par_err(pe[1]),
`ifdef PAR_ERR_CNT_EN
        .err_cnt(ec1),
`endif
        .par_ack(ack[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ec(input int sel, input string tag);
`ifdef PAR_ERR_CNT_EN
        chk(tag, (sel == 0) ? ec8 : ec1, exp_ec[sel]);
`endif
    endtask

    // Sends n data bits (LSB first) and then the parity bit, then checks the
    // held result one cycle after the parity transfer.
    task automatic send_frame(input int sel, input int n, input logic [31:0] data,
                              input bit md, input bit toggle, input bit par, input bit gaps);
        int ones;
        ones = 0;
        for (int i = 0; i <= n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    valid[sel] = 1'b0;
                    bin[sel]   = 1'($urandom % 2);
                end
            end
            @(negedge clk);
            chk("bit_ready_in_frame", ready[sel], 1);
            valid[sel] = 1'b1;
            bin[sel]   = (i < n) ? data[i] : par;
            if (i == 0) mode[sel] = md;
            else if (toggle) mode[sel] = ~mode[sel];
            ack[sel] = (i < n) ? 1'($urandom % 2) : 1'b0;
            if (i < n) ones += int'(data[i]);
        end
        @(negedge clk);
        valid[sel] = 1'b0;
        ack[sel]   = 1'b0;
        exp_po[sel] = 1'((ones % 2) != 0) ^ md;
        exp_pe[sel] = exp_po[sel] ^ par;
        if (exp_pe[sel] && exp_ec[sel] < 255) exp_ec[sel]++;
        chk("par_valid_after_parity", pv[sel], 1);
        chk("par_out", po[sel], exp_po[sel]);
        chk("par_err", pe[sel], exp_pe[sel]);
        chk("bit_ready_in_hold", ready[sel], 0);
        chk_ec(sel, "err_cnt");
    endtask

    task automatic hold_release(input int sel, input int cycles);
        repeat (cycles) begin
            valid[sel] = 1'($urandom % 2);
            bin[sel]   = 1'($urandom % 2);
            @(negedge clk);
            chk("hold_par_valid", pv[sel], 1);
            chk("hold_par_out", po[sel], exp_po[sel]);
            chk("hold_par_err", pe[sel], exp_pe[sel]);
            chk("hold_bit_ready", ready[sel], 0);
        end
        valid[sel] = 1'b0;
        ack[sel]   = 1'b1;
        @(negedge clk);
        ack[sel] = 1'b0;
        chk("ack_par_valid", pv[sel], 0);
        chk("ack_bit_ready", ready[sel], 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        bit          p;
        rst_n = 1'b0;
        mode  = '0; valid = '0; bin = '0; ack = '0;
        exp_ec[0] = 0; exp_ec[1] = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_par_valid", pv[s], 0);
            chk("rst_par_out", po[s], 0);
            chk("rst_par_err", pe[s], 0);
            chk("rst_bit_ready", ready[s], 1);
            chk_ec(s, "rst_err_cnt");
        end
        rst_n = 1'b1;

        // Directed frames: data 1,0,1,1,0,0,0,0
        send_frame(0, 8, 32'h0D, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("even_ok_out", po[0], 1);
        chk("even_ok_err", pe[0], 0);
        hold_release(0, 0);
        send_frame(0, 8, 32'h0D, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("even_bad_err", pe[0], 1);
        hold_release(0, 0);
        send_frame(0, 8, 32'h0D, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("odd_toggle_out", po[0], 0);
        chk("odd_toggle_err", pe[0], 0);
        hold_release(0, 5);

        // Reset after four data bits
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid[0] = 1'b1;
            bin[0]   = 1'b1;
        end
        @(negedge clk);
        valid[0] = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_par_valid", pv[0], 0);
        chk("midrst_bit_ready", ready[0], 1);
        exp_ec[0] = 0; exp_ec[1] = 0;
        chk_ec(0, "midrst_err_cnt");
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(0, 8, 32'hB7, 1'b0, 1'b0, 1'b0, 1'b1);
        hold_release(0, 1);

        // Reset while holding an error result
        send_frame(0, 8, 32'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("holdrst_par_valid", pv[0], 0);
        chk("holdrst_par_out", po[0], 0);
        chk("holdrst_par_err", pe[0], 0);
        chk("holdrst_bit_ready", ready[0], 1);
        exp_ec[0] = 0; exp_ec[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized frames on the 8-bit instance
        for (int f = 0; f < 40; f++) begin
            d = $urandom;
            p = 1'($urandom % 2);
            send_frame(0, 8, d & 32'hFF, 1'($urandom % 2), 1'($urandom % 2), p, 1'b1);
            hold_release(0, $urandom_range(0, 3));
        end

        // Single-bit frames, then saturate the error counter
        send_frame(1, 1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("len1_out", po[1], 1);
        chk("len1_err", pe[1], 0);
        hold_release(1, 0);
        for (int f = 0; f < 256; f++) begin
            d = 32'($urandom % 2);
            send_frame(1, 1, d, 1'b0, 1'b0, ~d[0], 1'b0);
            hold_release(1, 0);
        end
`ifdef PAR_ERR_CNT_EN
        chk("err_cnt_saturated", ec1, 255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8, giving the number of data bits per frame, legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port mode_odd, input, 1 bit: 0 selects even parity, 1 selects odd parity; sampled only when the first data bit of a frame is accepted.
REQ-005 The block SHALL have port bit_valid, input, 1 bit, meaning the upstream serial bit is present.
REQ-006 The block SHALL have port bit_in, input, 1 bit, the serial data or parity bit.
REQ-007 The block SHALL have port bit_ready, output, 1 bit, meaning the block accepts bit_in this cycle.
REQ-008 The block SHALL have port par_valid, output, 1 bit, meaning the frame result is held.
REQ-009 The block SHALL have port par_out, output, 1 bit, the computed expected parity bit of the frame.
REQ-010 The block SHALL have port par_err, output, 1 bit, meaning the received parity bit differs from par_out.
REQ-011 The block SHALL have port par_ack, input, 1 bit, the downstream consumption of the result.

Function
REQ-012 A transfer SHALL occur only on a clk edge where bit_valid and bit_ready are both 1.
REQ-013 The FSM SHALL have states IDLE, DATA, CHECK and HOLD; bit_ready SHALL be 1 in IDLE, DATA and CHECK, and 0 in HOLD.
REQ-014 In IDLE, a transfer SHALL load acc = bit_in XOR mode_odd and cnt = 1, then go to CHECK if FRAME_LEN = 1, else to DATA.
REQ-015 In DATA, each transfer SHALL set acc = acc XOR bit_in and increment cnt; when cnt reaches FRAME_LEN, the FSM SHALL go to CHECK.
REQ-016 The cnt register SHALL be $clog2(FRAME_LEN+1) bits wide and SHALL never wrap within a frame.
REQ-017 In CHECK, the transfer (the received parity bit) SHALL register par_out = acc and par_err = acc XOR bit_in, and go to HOLD.
REQ-018 par_valid SHALL be 1 exactly while in HOLD, starting the cycle after the parity-bit transfer, giving 1-cycle latency.
REQ-019 par_out and par_err SHALL remain stable throughout HOLD.
REQ-020 In HOLD, par_ack = 1 SHALL return the FSM to IDLE on that edge; the next frame's first bit SHALL be accepted no earlier than the following cycle.
REQ-021 par_ack outside HOLD SHALL be ignored.
REQ-022 Idle cycles (bit_valid = 0) in any state SHALL leave all state unchanged.
REQ-023 A change of mode_odd mid-frame SHALL NOT affect the current frame.

Reset
REQ-024 When rst_n = 0, the block SHALL immediately enter IDLE with acc = 0, cnt = 0, par_valid = 0, par_out = 0 and par_err = 0, regardless of clk.
REQ-025 Reset asserted mid-frame or during HOLD SHALL discard the partial frame or held result; bit_ready SHALL read 1 after reset.

Configuration
REQ-026 When macro PAR_ERR_CNT_EN is defined, the block SHALL add output err_cnt, 8 bits, reset to 0, incremented on each entry to HOLD with par_err = 1 and saturating at 255.
REQ-027 When PAR_ERR_CNT_EN is undefined, the err_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 FRAME_LEN=8, mode_odd=0, data 1,0,1,1,0,0,0,0 then parity 1 -> next cycle par_valid=1, par_out=1, par_err=0.
REQ-029 Same data, parity 0 -> par_out=1, par_err=1; with PAR_ERR_CNT_EN, err_cnt increments 0 -> 1.
REQ-030 mode_odd=1, same data, parity 0 -> par_out=0, par_err=0; toggling mode_odd mid-frame leaves the result unchanged.
REQ-031 Hold par_ack=0 for 5 cycles in HOLD -> bit_ready=0 and outputs stable; par_ack=1 -> IDLE and bit_ready=1.
REQ-032 Assert rst_n=0 after 4 data bits -> par_valid=0 and bit_ready=1 at once; a fresh 8-bit frame then computes correctly.
REQ-033 FRAME_LEN=1, data 1, parity 1, even mode -> par_out=1, par_err=0; 256 error frames with PAR_ERR_CNT_EN -> err_cnt=255.
